// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared constants and types for the register-file
// write-back arbiter.
//   REG_AW     register address width (16 registers)
//   DATA_W     register data width
//   NREGS      number of architectural registers
//   wb_entry_t port-B FIFO entry, packed MSB..LSB as {live, addr, data}
//   reg_onehot one-hot decode of a register address
package regfile_wb_pkg;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bus bundle between the execute/memory stages and
// the write-back arbiter.
//   A_VALID/A_ADDR/A_DATA          ALU result stream, no backpressure
//   B_VALID/B_READY/B_ADDR/B_DATA  load/multiply stream, valid/ready
//   WEN (active-low)/WA/WD         register-file write port
//   PEND_MASK                      per-register pending port-B write
// modport slave is the arbiter side, modport master the pipeline side.
interface regfile_wb_arbiter_if;
  import regfile_wb_pkg::*;

  logic              A_VALID;
  logic [REG_AW-1:0] A_ADDR;
  logic [DATA_W-1:0] A_DATA;
  logic              B_VALID;
  logic              B_READY;
  logic [REG_AW-1:0] B_ADDR;
  logic [DATA_W-1:0] B_DATA;
  logic              WEN;
  logic [REG_AW-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic [NREGS-1:0]  PEND_MASK;

  modport slave (
    input  A_VALID, A_ADDR, A_DATA,
    input  B_VALID, B_ADDR, B_DATA,
    output B_READY,
    output WEN, WA, WD,
    output PEND_MASK
  );

  modport master (
    output A_VALID, A_ADDR, A_DATA,
    output B_VALID, B_ADDR, B_DATA,
    input  B_READY,
    input  WEN, WA, WD,
    input  PEND_MASK
  );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order queue for port-B write-back results.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i/push_entry_i enqueue an entry at the tail (ignored when full)
//   pop_i              discard the head entry (ignored when empty)
//   kill_i/kill_addr_i clear the live bit of every queued entry to that reg
//   head_o             current head entry
//   empty_o/full_o     occupancy flags from the registered count
//   pend_mask_o        one-hot OR of the addresses of live queued entries
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [REG_AW-1:0] kill_addr_i,
  output wb_entry_t         head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [NREGS-1:0]  pend_mask_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Popped slots have their live bit cleared so that every free slot is
  // dead; PEND_MASK can then OR all slots without consulting the pointers.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_i && (mem_q[i].addr == kill_addr_i)) begin
        mem_d[i].live = 1'b0;
      end
    end
    if (pop_ok) begin
      mem_d[rd_ptr_q].live = 1'b0;
    end
    // A new entry arrives with its liveness already resolved against port A.
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry_i;
    end
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem_q[i].live) begin
        pend_mask_o = pend_mask_o | reg_onehot(mem_q[i].addr);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the ALU stream (port A) and the load/multiply
// stream (port B) onto the single register-file write port.
//   CLK     clock, all state on the rising edge
//   nRESET  asynchronous active-low reset
//   bus     regfile_wb_arbiter_if.slave: A/B request streams, B_READY,
//           registered write port WEN/WA/WD, PEND_MASK interlock mask
// Priority per cycle: A write, live FIFO head, dead FIFO head (pop only),
// then same-cycle B bypass when the FIFO is empty.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  regfile_wb_arbiter_if.slave   bus
);

  wb_entry_t         fifo_head;
  wb_entry_t         push_entry;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              b_xfer, kill_b;
  logic [NREGS-1:0]  pend_mask;

  logic              wen_q, wen_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (CLK),
    .rst_ni       (nRESET),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (bus.A_VALID),
    .kill_addr_i  (bus.A_ADDR),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .pend_mask_o  (pend_mask)
  );

  always_comb begin
    b_xfer = bus.B_VALID & ~fifo_full;
    // Port A is newer than a same-cycle B result to the same register, so
    // that B result is queued dead and must never take the bypass path.
    kill_b = bus.A_VALID && (bus.A_ADDR == bus.B_ADDR);
    push_entry = '{live: ~kill_b, addr: bus.B_ADDR, data: bus.B_DATA};

    push  = 1'b0;
    pop   = 1'b0;
    wen_d = 1'b1;
    wa_d  = wa_q;
    wd_d  = wd_q;

    if (bus.A_VALID) begin
      wen_d = 1'b0;
      wa_d  = bus.A_ADDR;
      wd_d  = bus.A_DATA;
      push  = b_xfer;
    end else if (!fifo_empty) begin
      pop  = 1'b1;
      push = b_xfer;
      if (fifo_head.live) begin
        wen_d = 1'b0;
        wa_d  = fifo_head.addr;
        wd_d  = fifo_head.data;
      end
    end else if (b_xfer) begin
      wen_d = 1'b0;
      wa_d  = bus.B_ADDR;
      wd_d  = bus.B_DATA;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wen_q <= 1'b1;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      wen_q <= wen_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
    end
  end

  assign bus.B_READY   = ~fifo_full;
  assign bus.WEN       = wen_q;
  assign bus.WA        = wa_q;
  assign bus.WD        = wd_q;
  assign bus.PEND_MASK = pend_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
// with DEPTH=2. Inputs change 1 time unit after each rising edge; outputs
// are sampled at the same point, reflecting the selection made in the
// cycle just ended.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DEPTH (2)
  ) dut (
    .CLK    (clk),
    .nRESET (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [3:0] a, input logic [31:0] d);
    bus.A_VALID = v;
    bus.A_ADDR  = a;
    bus.A_DATA  = d;
  endtask

  task automatic set_b(input logic v, input logic [3:0] a, input logic [31:0] d);
    bus.B_VALID = v;
    bus.B_ADDR  = a;
    bus.B_DATA  = d;
  endtask

  task automatic idle();
    set_a(1'b0, 4'h0, 32'h0);
    set_b(1'b0, 4'h0, 32'h0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the complete write-port / status picture after an edge.
  task automatic expect_out(input string tag, input logic wen, input logic [3:0] wa,
                            input logic [31:0] wd, input logic [15:0] pend,
                            input logic rdy);
    check({tag, ".WEN"},       {31'h0, bus.WEN},     {31'h0, wen});
    check({tag, ".WA"},        {28'h0, bus.WA},      {28'h0, wa});
    check({tag, ".WD"},        bus.WD,               wd);
    check({tag, ".PEND_MASK"}, {16'h0, bus.PEND_MASK}, {16'h0, pend});
    check({tag, ".B_READY"},   {31'h0, bus.B_READY}, {31'h0, rdy});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      set_a(1'($urandom), 4'($urandom), $urandom);
      set_b(1'($urandom), 4'($urandom), $urandom);
      tick();
      expect_out("rst_hold", 1'b1, 4'h0, 32'h0, 16'h0, 1'b1);
    end

    // Release; first ALU write lands one cycle later.
    rst_n = 1'b1;
    idle();
    set_a(1'b1, 4'd3, 32'h11);
    tick();
    expect_out("first_a", 1'b0, 4'd3, 32'h11, 16'h0, 1'b1);
    idle();
    tick();
    expect_out("idle_hold", 1'b1, 4'd3, 32'h11, 16'h0, 1'b1);

    // Contention: A wins, B queued then written next cycle.
    set_a(1'b1, 4'd1, 32'hA);
    set_b(1'b1, 4'd2, 32'hB);
    tick();
    expect_out("cont_a", 1'b0, 4'd1, 32'hA, 16'h0004, 1'b1);
    idle();
    tick();
    expect_out("cont_b", 1'b0, 4'd2, 32'hB, 16'h0000, 1'b1);
    tick();
    expect_out("cont_idle", 1'b1, 4'd2, 32'hB, 16'h0000, 1'b1);

    // Kill: queue r5 behind an A write to r4, then A writes r5.
    set_a(1'b1, 4'd4, 32'h44);
    set_b(1'b1, 4'd5, 32'h55);
    tick();
    expect_out("kill_q", 1'b0, 4'd4, 32'h44, 16'h0020, 1'b1);
    idle();
    set_a(1'b1, 4'd5, 32'h99);
    tick();
    expect_out("kill_a", 1'b0, 4'd5, 32'h99, 16'h0000, 1'b1);
    idle();
    tick();
    expect_out("kill_drain", 1'b1, 4'd5, 32'h99, 16'h0000, 1'b1);
    tick();
    expect_out("kill_idle", 1'b1, 4'd5, 32'h99, 16'h0000, 1'b1);

    // Same-cycle kill: B to r7 enqueued dead, never bypassed.
    set_a(1'b1, 4'd7, 32'h1);
    set_b(1'b1, 4'd7, 32'h2);
    tick();
    expect_out("same_a", 1'b0, 4'd7, 32'h1, 16'h0000, 1'b1);
    idle();
    tick();
    expect_out("same_drain", 1'b1, 4'd7, 32'h1, 16'h0000, 1'b1);
    tick();
    expect_out("same_idle", 1'b1, 4'd7, 32'h1, 16'h0000, 1'b1);

    // Backpressure: A held for 4 cycles while B offers requests.
    set_a(1'b1, 4'd8, 32'h80);
    set_b(1'b1, 4'd9, 32'h90);
    tick();
    expect_out("bp_1", 1'b0, 4'd8, 32'h80, 16'h0200, 1'b1);
    set_a(1'b1, 4'd8, 32'h81);
    set_b(1'b1, 4'd10, 32'hA0);
    tick();
    expect_out("bp_2", 1'b0, 4'd8, 32'h81, 16'h0600, 1'b0);
    set_a(1'b1, 4'd8, 32'h82);
    set_b(1'b1, 4'd11, 32'hB0);
    tick();
    expect_out("bp_3", 1'b0, 4'd8, 32'h82, 16'h0600, 1'b0);
    set_a(1'b1, 4'd8, 32'h83);
    tick();
    expect_out("bp_4", 1'b0, 4'd8, 32'h83, 16'h0600, 1'b0);
    // A stops; r11 still offered but refused this cycle (full).
    set_a(1'b0, 4'd0, 32'h0);
    tick();
    expect_out("bp_pop1", 1'b0, 4'd9, 32'h90, 16'h0400, 1'b1);
    // Pop r10 while r11 is accepted: push and pop together.
    tick();
    expect_out("bp_pop2", 1'b0, 4'd10, 32'hA0, 16'h0800, 1'b1);
    set_b(1'b1, 4'd12, 32'hC0);
    tick();
    expect_out("bp_pop3", 1'b0, 4'd11, 32'hB0, 16'h1000, 1'b1);
    set_b(1'b0, 4'd0, 32'h0);
    tick();
    expect_out("bp_pop4", 1'b0, 4'd12, 32'hC0, 16'h0000, 1'b1);
    tick();
    expect_out("bp_idle", 1'b1, 4'd12, 32'hC0, 16'h0000, 1'b1);

    // Reset mid-drain with two live entries queued.
    set_a(1'b1, 4'd1, 32'h1);
    set_b(1'b1, 4'd2, 32'h22);
    tick();
    set_a(1'b1, 4'd1, 32'h2);
    set_b(1'b1, 4'd3, 32'h33);
    tick();
    expect_out("mid_full", 1'b0, 4'd1, 32'h2, 16'h000C, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    expect_out("mid_async", 1'b1, 4'd0, 32'h0, 16'h0000, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("mid_post1", 1'b1, 4'd0, 32'h0, 16'h0000, 1'b1);
    tick();
    expect_out("mid_post2", 1'b1, 4'd0, 32'h0, 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
